layer_mem_write: RTL and testbench

Parametrised write-address generator for layer output memories (conv/pool feature maps).
- Splits a buffer of TOTAL_WORDS words into NUM_PORTS equal contiguous segments, one per memory write port.
- Steps all ports in lockstep, one word per accepted beat.
- Has an explicit start/busy/done handshake and clean restart between frames.
- Sits between a layer's compute datapath and its output RAM banks.

---
 rtl/cnn_mem_pkg.sv | 20 ++
 rtl/seg_index_counter.sv | 43 ++++
 rtl/layer_mem_write.sv | 144 ++++++++++++++
 tb/tb_layer_mem_write.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for CNN layer memory address generation.
package cnn_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Feature-map geometry of the first pool and conv layers.
  localparam int POOL1_W     = 12;
  localparam int POOL1_WORDS = POOL1_W * POOL1_W;
  localparam int CONV1_W     = 24;
  localparam int CONV1_WORDS = CONV1_W * CONV1_W;

  function automatic int seg_words(input int total_words, input int num_ports);
    return total_words / num_ports;
  endfunction

endpackage

// File: rtl/seg_index_counter.sv
// Modulo-MAX index counter with clear, enable and a terminal-count flag.
// With WRAP=0 it saturates at MAX-1; with WRAP=1 it rolls over to zero.
module seg_index_counter #(
  parameter int W    = 8,
  parameter int MAX  = 1,
  parameter bit WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == W'(MAX - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (!tc) begin
        cnt_d = cnt_q + W'(1);
      end else if (WRAP) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_mem_write.sv
// Lockstep write-address generator splitting one output buffer across NUM_PORTS banks.
// Optional row/col image coordinates of port 0 under LAYER_MEM_WRITE_ROWCOL_EN.
module layer_mem_write
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TOTAL_WORDS = POOL1_WORDS,
  parameter int NUM_PORTS   = 2,
  parameter int IMG_W       = POOL1_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          enable,
  output logic [NUM_PORTS*ADDR_W-1:0]   addr,
  output logic [NUM_PORTS-1:0]          we,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             idx
`ifdef LAYER_MEM_WRITE_ROWCOL_EN
  ,
  output logic [ADDR_W-1:0]             row,
  output logic [ADDR_W-1:0]             col
`endif
);

  localparam int SEG = seg_words(TOTAL_WORDS, NUM_PORTS);

  if (TOTAL_WORDS % NUM_PORTS != 0) begin : g_bad_split
    $fatal(1, "layer_mem_write: TOTAL_WORDS not divisible by NUM_PORTS");
  end
  if (TOTAL_WORDS - 1 >= (1 << ADDR_W)) begin : g_bad_width
    $fatal(1, "layer_mem_write: ADDR_W too narrow for TOTAL_WORDS");
  end
  if (IMG_W < 1) begin : g_bad_img
    $fatal(1, "layer_mem_write: IMG_W must be positive");
  end

  state_e            state_q;
  state_e            state_d;
  logic              beat;
  logic              idx_clear;
  logic              idx_tc;
  logic [ADDR_W-1:0] idx_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (enable && idx_tc) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    beat = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy = 1'b1;
        beat = enable;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Restart only outside RUN; a start during RUN is ignored.
  assign idx_clear = start && (state_q != ST_RUN);

  seg_index_counter #(
    .W    (ADDR_W),
    .MAX  (SEG),
    .WRAP (1'b0)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .clear (idx_clear),
    .en    (beat),
    .cnt   (idx_cnt),
    .tc    (idx_tc)
  );

  assign idx = idx_cnt;
  assign we  = {NUM_PORTS{beat}};

  // Idle shows the bases (idx=0) and DONE the last words (idx=SEG-1) for free.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign addr[gi*ADDR_W +: ADDR_W] = ADDR_W'(gi * SEG) + idx_cnt;
  end

`ifdef LAYER_MEM_WRITE_ROWCOL_EN
  if (SEG % IMG_W != 0) begin : g_bad_rows
    $fatal(1, "layer_mem_write: segment is not a whole number of rows");
  end

  logic col_en;
  logic col_tc;
  logic row_tc;

  // The final beat leaves row/col on the last written word.
  assign col_en = beat && !idx_tc;

  seg_index_counter #(
    .W    (ADDR_W),
    .MAX  (IMG_W),
    .WRAP (1'b1)
  ) u_col (
    .clk   (clk),
    .reset (reset),
    .clear (idx_clear),
    .en    (col_en),
    .cnt   (col),
    .tc    (col_tc)
  );

  seg_index_counter #(
    .W    (ADDR_W),
    .MAX  (SEG / IMG_W),
    .WRAP (1'b0)
  ) u_row (
    .clk   (clk),
    .reset (reset),
    .clear (idx_clear),
    .en    (col_en && col_tc),
    .cnt   (row),
    .tc    (row_tc)
  );

  logic unused_row_tc;
  assign unused_row_tc = row_tc;
`endif

endmodule

// File: tb/tb_layer_mem_write.sv
// Scoreboard bench for layer_mem_write: default 2-port frame plus 4-port and 1-word instances.
module tb_layer_mem_write;

  logic        clk = 1'b0;
  logic        reset, start, enable;
  logic [15:0] addr_m;
  logic [1:0]  we_m;
  logic        busy_m, done_m;
  logic [7:0]  idx_m;

  logic        s4, e4;
  logic [31:0] addr4;
  logic [3:0]  we4;
  logic        busy4, done4;
  logic [7:0]  idx4;

  logic        s1, e1;
  logic [7:0]  addr1;
  logic [0:0]  we1;
  logic        busy1, done1;
  logic [7:0]  idx1;

`ifdef LAYER_MEM_WRITE_ROWCOL_EN
  logic [7:0] row_m, col_m, row4, col4, row1, col1;
`endif

  always #5 clk = ~clk;

  layer_mem_write dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable),
    .addr(addr_m), .we(we_m), .busy(busy_m), .done(done_m), .idx(idx_m)
`ifdef LAYER_MEM_WRITE_ROWCOL_EN
    , .row(row_m), .col(col_m)
`endif
  );

  layer_mem_write #(.ADDR_W(8), .TOTAL_WORDS(16), .NUM_PORTS(4), .IMG_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(s4), .enable(e4),
    .addr(addr4), .we(we4), .busy(busy4), .done(done4), .idx(idx4)
`ifdef LAYER_MEM_WRITE_ROWCOL_EN
    , .row(row4), .col(col4)
`endif
  );

  layer_mem_write #(.ADDR_W(8), .TOTAL_WORDS(1), .NUM_PORTS(1), .IMG_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(s1), .enable(e1),
    .addr(addr1), .we(we1), .busy(busy1), .done(done1), .idx(idx1)
`ifdef LAYER_MEM_WRITE_ROWCOL_EN
    , .row(row1), .col(col1)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    int          idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulse_cnt = 0;
  int   m_idx = 0;
  bit   m_run = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit with_en);
    start  = 1'b1;
    enable = with_en;
    tick();
    start  = 1'b0;
    enable = 1'b0;
    m_idx  = 0;
    m_run  = 1'b1;
  endtask

  // One cycle of upstream traffic; the model pushes the write it expects.
  task automatic beat(input bit en);
    exp_t e;
    enable = en;
    if (en && m_run) begin
      e.addr = {8'(72 + m_idx), 8'(m_idx)};
      e.idx  = m_idx;
      sb_q.push_back(e);
      if (m_idx == 71) m_run = 1'b0;
      else             m_idx++;
    end
    tick();
    enable = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (we_m != 2'b00) begin
      pulse_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("we_unexpected", 32'(we_m), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("beat_addr", 32'(addr_m), 32'(e.addr));
        check_eq("beat_we", 32'(we_m), 32'h3);
`ifdef LAYER_MEM_WRITE_ROWCOL_EN
        check_eq("beat_row", 32'(row_m), 32'(e.idx / 12));
        check_eq("beat_col", 32'(col_m), 32'(e.idx % 12));
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; enable = 1'b0;
    s4 = 1'b0; e4 = 1'b0; s1 = 1'b0; e1 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_eq("rst_idx", 32'(idx_m), 32'd0);
    check_eq("rst_addr", 32'(addr_m), 32'h4800);
    check_eq("rst_busy", 32'(busy_m), 32'd0);
    check_eq("rst_done", 32'(done_m), 32'd0);
    check_eq("rst_we", 32'(we_m), 32'd0);
    check_eq("rst_addr4", addr4, 32'h0C080400);
    check_eq("rst_addr1", 32'(addr1), 32'd0);

    // Frame A: back-to-back beats.
    pulse_cnt = 0;
    do_start(1'b0);
    check_eq("a_busy", 32'(busy_m), 32'd1);
    for (int k = 0; k < 72; k++) beat(1'b1);
    check_eq("a_done", 32'(done_m), 32'd1);
    check_eq("a_busy_low", 32'(busy_m), 32'd0);
    check_eq("a_last_addr", 32'(addr_m), 32'h8F47);
    check_eq("a_last_idx", 32'(idx_m), 32'd71);
    repeat (3) beat(1'b1);
    check_eq("a_done_hold", 32'(done_m), 32'd1);
    check_eq("a_pulses", 32'(pulse_cnt), 32'd72);

    // Frame B: restart from DONE with enable in the start cycle, random gaps.
    pulse_cnt = 0;
    do_start(1'b1);
    check_eq("b_done_drop", 32'(done_m), 32'd0);
    check_eq("b_busy", 32'(busy_m), 32'd1);
    check_eq("b_addr_base", 32'(addr_m), 32'h4800);
    for (int k = 0; k < 1000 && m_run; k++) beat(1'($urandom_range(0, 1)));
    check_eq("b_done", 32'(done_m), 32'd1);
    check_eq("b_pulses", 32'(pulse_cnt), 32'd72);

    // Frame C: reset mid-run, then a full frame.
    pulse_cnt = 0;
    do_start(1'b0);
    for (int k = 0; k < 30; k++) beat(1'b1);
    check_eq("c_idx30", 32'(idx_m), 32'd30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_run = 1'b0;
    check_eq("c_rst_idx", 32'(idx_m), 32'd0);
    check_eq("c_rst_addr", 32'(addr_m), 32'h4800);
    check_eq("c_rst_busy", 32'(busy_m), 32'd0);
    check_eq("c_rst_done", 32'(done_m), 32'd0);
    repeat (2) beat(1'b1);
    check_eq("c_pulses", 32'(pulse_cnt), 32'd30);
    pulse_cnt = 0;
    do_start(1'b0);
    for (int k = 0; k < 72; k++) beat(1'b1);
    check_eq("c_done", 32'(done_m), 32'd1);
    check_eq("c_pulses_full", 32'(pulse_cnt), 32'd72);

    // Four ports, 16 words.
    s4 = 1'b1;
    tick();
    s4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e4 = 1'b1;
      #1;
      check_eq("p4_we", 32'(we4), 32'hF);
      check_eq("p4_addr", addr4, {8'(12 + k), 8'(8 + k), 8'(4 + k), 8'(k)});
      tick();
      e4 = 1'b0;
    end
    check_eq("p4_done", 32'(done4), 32'd1);
    e4 = 1'b1;
    #1;
    check_eq("p4_we_done", 32'(we4), 32'd0);
    tick();
    e4 = 1'b0;

    // One port, one word.
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    e1 = 1'b1;
    #1;
    check_eq("p1_we", 32'(we1), 32'd1);
    check_eq("p1_addr", 32'(addr1), 32'd0);
    tick();
    check_eq("p1_done", 32'(done1), 32'd1);
    check_eq("p1_we_done", 32'(we1), 32'd0);
    e1 = 1'b0;

    tick();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
